// File: rtl/fifo_access_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_access_scheduler
//
// Sequences every access to a single FIFO instance whose write and read must
// never be issued in the same cycle. N_REQ producers compete round-robin for
// the write side; a single consumer owns the read side. When both sides are
// eligible they strictly alternate. The scheduler tracks occupancy itself so
// the FIFO is never overrun or underrun. The FIFO flags are only watched to
// raise a sticky error if they ever disagree with an issued operation.
//
// Ports:
//   clk, rstN        clock, asynchronous active-low reset (shared with FIFO)
//   wr_req/wr_data   per-producer write request (held until granted) + data
//   wr_gnt           one-hot combinational write grant
//   rd_req/rd_gnt    consumer read request / combinational read grant
//   rd_data/rd_valid read data (FIFO pass-through) and its one-cycle strobe
//   fifo_wr_en, fifo_data_in, fifo_rd_en   registered FIFO controls
//   fifo_data_out, fifo_full, fifo_empty   FIFO outputs
//   level            scheduler occupancy count
//   err              sticky protocol-error flag
// -----------------------------------------------------------------------------
module fifo_access_scheduler #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 6
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [N_REQ-1:0]            wr_req,
    input  logic [N_REQ*FIFO_WIDTH-1:0] wr_data,
    output logic [N_REQ-1:0]            wr_gnt,
    input  logic                        rd_req,
    output logic                        rd_gnt,
    output logic [FIFO_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic                        fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    output logic                        fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0]       fifo_data_out,
    input  logic                        fifo_full,
    input  logic                        fifo_empty,
    output logic [CNT_W-1:0]            level,
    output logic                        err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE_C  = N_REQ'(1);

    // Contention turn: which side wins when both are eligible.
    localparam logic [0:0] TURN_WR = 1'b0;
    localparam logic [0:0] TURN_RD = 1'b1;

    // Registered state
    logic [0:0]            turn_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [CNT_W-1:0]      level_r;
    logic                  fifo_wr_en_r;
    logic                  fifo_rd_en_r;
    logic [FIFO_WIDTH-1:0] fifo_data_in_r;
    logic                  rd_valid_r;
    logic                  err_r;

    // Combinational decisions
    logic                  wr_cand_s;
    logic                  rd_cand_s;
    logic                  wr_found_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [FIFO_WIDTH-1:0] wr_sel_data_s;
    logic                  wr_win_s;
    logic                  rd_win_s;
    logic [N_REQ-1:0]      wr_gnt_s;
    logic                  rd_gnt_s;

    assign wr_cand_s = (|wr_req) && (level_r < DEPTH_C);
    assign rd_cand_s = rd_req && (level_r != CNT_ZERO_C);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int cand_v;
        wr_found_s = 1'b0;
        wr_idx_s   = {IDX_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_v = (int'(rr_ptr_r) + k) % N_REQ;
            if (!wr_found_s && wr_req[IDX_W'(cand_v)]) begin
                wr_found_s = 1'b1;
                wr_idx_s   = IDX_W'(cand_v);
            end else begin
                wr_found_s = wr_found_s;
            end
        end
    end

    // Data slice of the selected requester.
    always_comb begin
        wr_sel_data_s = {FIFO_WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (wr_idx_s == IDX_W'(i)) begin
                wr_sel_data_s = wr_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end else begin
                wr_sel_data_s = wr_sel_data_s;
            end
        end
    end

    // Write/read choice: a lone candidate wins, contention follows turn_r.
    always_comb begin
        wr_win_s = 1'b0;
        rd_win_s = 1'b0;
        if (wr_cand_s && rd_cand_s) begin
            case (turn_r)
                TURN_WR: wr_win_s = 1'b1;
                TURN_RD: rd_win_s = 1'b1;
                default: wr_win_s = 1'b1;
            endcase
        end else if (wr_cand_s) begin
            wr_win_s = wr_found_s;
        end else if (rd_cand_s) begin
            rd_win_s = 1'b1;
        end else begin
            wr_win_s = 1'b0;
            rd_win_s = 1'b0;
        end
    end

    // Grant outputs, held low while reset is asserted.
    always_comb begin
        wr_gnt_s = {N_REQ{1'b0}};
        rd_gnt_s = 1'b0;
        if (rstN && wr_win_s) begin
            wr_gnt_s = GNT_ONE_C << wr_idx_s;
        end else if (rstN && rd_win_s) begin
            rd_gnt_s = 1'b1;
        end else begin
            wr_gnt_s = {N_REQ{1'b0}};
            rd_gnt_s = 1'b0;
        end
    end

    // Issue registers, occupancy count, turn and round-robin pointer.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            turn_r         <= TURN_WR;
            rr_ptr_r       <= LAST_IDX_C;
            level_r        <= CNT_ZERO_C;
            fifo_wr_en_r   <= 1'b0;
            fifo_rd_en_r   <= 1'b0;
            fifo_data_in_r <= {FIFO_WIDTH{1'b0}};
        end else if (wr_win_s) begin
            turn_r         <= TURN_RD;
            rr_ptr_r       <= wr_idx_s;
            level_r        <= level_r + CNT_ONE_C;
            fifo_wr_en_r   <= 1'b1;
            fifo_rd_en_r   <= 1'b0;
            fifo_data_in_r <= wr_sel_data_s;
        end else if (rd_win_s) begin
            turn_r         <= TURN_WR;
            level_r        <= level_r - CNT_ONE_C;
            fifo_wr_en_r   <= 1'b0;
            fifo_rd_en_r   <= 1'b1;
        end else begin
            fifo_wr_en_r   <= 1'b0;
            fifo_rd_en_r   <= 1'b0;
        end
    end

    // Read-return strobe and sticky error (flags contradicting an issued op).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_valid_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rd_valid_r <= fifo_rd_en_r;
            err_r      <= err_r | (fifo_wr_en_r & fifo_full) | (fifo_rd_en_r & fifo_empty);
        end
    end

    assign wr_gnt       = wr_gnt_s;
    assign rd_gnt       = rd_gnt_s;
    assign rd_data      = fifo_data_out;
    assign rd_valid     = rd_valid_r;
    assign fifo_wr_en   = fifo_wr_en_r;
    assign fifo_rd_en   = fifo_rd_en_r;
    assign fifo_data_in = fifo_data_in_r;
    assign level        = level_r;
    assign err          = err_r;

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a small behavioural FIFO.
module tb_fifo_access_scheduler;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  wr_req;
    logic [31:0] wr_data;
    logic [3:0]  wr_gnt;
    logic        rd_req;
    logic        rd_gnt;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data_out;
    logic        fifo_full;
    logic        fifo_empty;
    logic [5:0]  level;
    logic        err;

    int errors = 0;
    int checks = 0;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    fifo_access_scheduler dut (
        .clk           (clk),
        .rstN          (rstN),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .rd_req        (rd_req),
        .rd_gnt        (rd_gnt),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .level         (level),
        .err           (err)
    );

    // Behavioural 8x32 FIFO: write sampled on edge, registered read data.
    logic [7:0] mem [0:31];
    logic [4:0] wp;
    logic [4:0] rp;
    logic [5:0] cnt;
    logic       force_full;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wp <= 5'd0;
            rp <= 5'd0;
            cnt <= 6'd0;
            fifo_data_out <= 8'd0;
        end else begin
            if (fifo_wr_en) begin
                mem[wp] <= fifo_data_in;
                wp <= wp + 5'd1;
            end
            if (fifo_rd_en) begin
                fifo_data_out <= mem[rp];
                rp <= rp + 5'd1;
            end
            if (fifo_wr_en && !fifo_rd_en) cnt <= cnt + 6'd1;
            else if (fifo_rd_en && !fifo_wr_en) cnt <= cnt - 6'd1;
        end
    end

    assign fifo_full  = (cnt == 6'd32) || force_full;
    assign fifo_empty = (cnt == 6'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        wr_req = 4'hF;
        rd_req = 1'b1;
        wr_data = 32'h0;
        force_full = 1'b0;
        #12;
        // Reset state, grants forced low even with requests present
        check("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        check("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check("rst_data_in", 32'(fifo_data_in), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        wr_req = 4'h0;
        rd_req = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;

        // Round-robin with all four requesting
        wr_req = 4'hF;
        wr_data = 32'h44332211;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_gnt", 32'(wr_gnt), 32'h1 << exp_order[k]);
            step();
            check("rr_data", 32'(fifo_data_in), 32'h11 * (exp_order[k] + 1));
        end
        check("rr_level6", 32'(level), 32'd6);
        #1;
        check("rr_gnt7", 32'(wr_gnt), 32'h4);
        step();
        check("pre_rst_level7", 32'(level), 32'd7);
        check("pre_rst_wr_en", 32'(fifo_wr_en), 32'h1);

        // Asynchronous reset mid-run
        rstN = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 32'h0);
        check("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("mid_rst_data_in", 32'(fifo_data_in), 32'h0);
        check("mid_rst_wr_gnt", 32'(wr_gnt), 32'h0);
        @(posedge clk);
        #1 rstN = 1'b1;
        #1;
        check("post_rst_req0_first", 32'(wr_gnt), 32'h1);

        // Single write from req0
        wr_req = 4'h1;
        wr_data = 32'h000000A5;
        #1;
        check("w0_gnt", 32'(wr_gnt), 32'h1);
        step();
        check("w0_wr_en", 32'(fifo_wr_en), 32'h1);
        check("w0_data_in", 32'(fifo_data_in), 32'hA5);
        check("w0_level", 32'(level), 32'd1);

        // Fill to capacity from req1
        wr_req = 4'h2;
        for (int i = 0; i < 31; i++) begin
            wr_data[15:8] = 8'h40 + 8'(i);
            #1;
            step();
        end
        check("full_level", 32'(level), 32'd32);
        check("full_last_wr_en", 32'(fifo_wr_en), 32'h1);
        #1;
        check("full_no_gnt", 32'(wr_gnt), 32'h0);
        step();
        check("full_wr_en_off", 32'(fifo_wr_en), 32'h0);
        check("full_err", 32'(err), 32'h0);
        check("full_level_hold", 32'(level), 32'd32);

        // One read at full; req1 gets the freed slot next
        rd_req = 1'b1;
        #1;
        check("full_rd_gnt", 32'(rd_gnt), 32'h1);
        check("full_rd_wr_gnt", 32'(wr_gnt), 32'h0);
        step();
        check("rd_level31", 32'(level), 32'd31);
        check("rd_en", 32'(fifo_rd_en), 32'h1);
        check("rd_valid_early", 32'(rd_valid), 32'h0);
        rd_req = 1'b0;
        #1;
        check("refill_gnt", 32'(wr_gnt), 32'h2);
        step();
        check("rd_valid", 32'(rd_valid), 32'h1);
        check("rd_data_first", 32'(rd_data), 32'hA5);
        check("refill_level", 32'(level), 32'd32);
        wr_req = 4'h0;
        step();
        check("rd_valid_pulse", 32'(rd_valid), 32'h0);

        // Drain to 5
        rd_req = 1'b1;
        for (int i = 0; i < 27; i++) step();
        check("drain_level5", 32'(level), 32'd5);

        // Contention alternates W,R,W,R
        wr_req = 4'h1;
        wr_data = 32'h0000005A;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_wr_gnt", 32'(wr_gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
            check("alt_rd_gnt", 32'(rd_gnt), (k % 2 == 0) ? 32'h0 : 32'h1);
            step();
            check("alt_level", 32'(level), (k % 2 == 0) ? 32'd6 : 32'd5);
            check("alt_exclusive", 32'(fifo_wr_en & fifo_rd_en), 32'h0);
        end

        // Drain to empty, then read request must be refused
        wr_req = 4'h0;
        for (int i = 0; i < 5; i++) step();
        check("empty_level", 32'(level), 32'd0);
        #1;
        check("empty_rd_gnt", 32'(rd_gnt), 32'h0);
        step();
        check("empty_rd_en", 32'(fifo_rd_en), 32'h0);
        check("empty_level_hold", 32'(level), 32'd0);
        check("empty_err", 32'(err), 32'h0);
        rd_req = 1'b0;

        // Full flag contradicting an issued write sets sticky err
        force_full = 1'b1;
        wr_req = 4'h1;
        #1;
        step();
        check("err_before", 32'(err), 32'h0);
        check("err_wr_en", 32'(fifo_wr_en), 32'h1);
        wr_req = 4'h0;
        step();
        check("err_set", 32'(err), 32'h1);
        force_full = 1'b0;
        step();
        step();
        check("err_sticky", 32'(err), 32'h1);
        rstN = 1'b0;
        #1;
        check("err_cleared", 32'(err), 32'h0);
        @(posedge clk);
        #1 rstN = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_access_scheduler.md
Name: fifo_access_scheduler

Overview:
Sequences all accesses to one single-port-style FIFO instance (FIFO_WIDTH x FIFO_DEPTH, write and read never in the same cycle). Arbitrates N_REQ producers round-robin for the write side and one consumer for the read side. Issues at most one FIFO operation per cycle and keeps its own occupancy count, so the FIFO is never overrun or underrun. Sits between the producer/consumer logic and the FIFO's wr_en/rd_en/data_in/data_out pins.

Parameters:
N_REQ, 4, number of write requesters
FIFO_WIDTH, 8, data width in bits
FIFO_DEPTH, 32, FIFO capacity in entries
CNT_W, 6, width of level counter; must hold FIFO_DEPTH

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
wr_req  in  N_REQ  per-producer write request; held until granted
wr_data  in  N_REQ*FIFO_WIDTH  producer data, slice i belongs to wr_req[i]
wr_gnt  out  N_REQ  one-hot combinational grant; transfer occurs on a clock edge where req&gnt are both high
rd_req  in  1  consumer read request
rd_gnt  out  1  combinational read grant
rd_data  out  FIFO_WIDTH  read data, valid when rd_valid is high
rd_valid  out  1  one-cycle pulse per completed read
fifo_wr_en  out  1  registered FIFO write enable
fifo_data_in  out  FIFO_WIDTH  registered FIFO write data
fifo_rd_en  out  1  registered FIFO read enable
fifo_data_out  in  FIFO_WIDTH  FIFO read data
fifo_full  in  1  FIFO full flag; used only for error checking
fifo_empty  in  1  FIFO empty flag; used only for error checking
level  out  CNT_W  scheduler occupancy count
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rstN low, asynchronous): level=0, fifo_wr_en=0, fifo_rd_en=0, fifo_data_in=0, rd_valid=0, err=0, turn=0 (write preferred), rr_ptr=N_REQ-1 (req0 has highest priority first). wr_gnt and rd_gnt are forced 0 while rstN is low.
- Eligibility, combinational:
  - wr_cand = |wr_req && level < FIFO_DEPTH.
  - rd_cand = rd_req && level != 0.
- Write/read choice:
  - Only one candidate: that candidate wins.
  - Both candidates: turn=0 selects write; turn=1 selects read.
  - On any grant, turn is set to 1 after a write and to 0 after a read. Contention therefore strictly alternates W,R,W,R.
- Writer selection: round-robin. Search indices rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ) and take the first index with wr_req set. On a write grant, rr_ptr takes the granted index.
- At most one bit is set across wr_gnt and rd_gnt in any cycle.
- Edge with write grant to index i:
  - fifo_wr_en<=1.
  - fifo_data_in<=wr_data[i].
  - level<=level+1.
  - The FIFO samples the write on the following edge (1-cycle issue latency).
- Edge with read grant:
  - fifo_rd_en<=1.
  - level<=level-1.
- Edge with no grant: fifo_wr_en<=0 and fifo_rd_en<=0. fifo_data_in holds its value.
- Read return path:
  - rd_valid<=fifo_rd_en.
  - rd_data = fifo_data_out, passed through.
  - rd_valid is high exactly 2 cycles after the cycle in which rd_gnt was high.
- level never exceeds FIFO_DEPTH and never goes below 0. Write and read are never both counted on the same edge.
- err is set on any edge where (fifo_wr_en && fifo_full) or (fifo_rd_en && fifo_empty). It is cleared only by reset.
- Reset mid-operation: any registered fifo_wr_en/fifo_rd_en or pending rd_valid is dropped. The FIFO shares rstN, so level=0 stays consistent with it.
- A requester that deasserts wr_req before being granted loses its turn with no side effects.

Test Plan:
- Reset asserted mid-run with level=7 and fifo_wr_en=1 -> all outputs 0 immediately, level=0; after release, req0 is granted first.
- wr_req=0001, wr_data[0]=0xA5, level=0 -> wr_gnt=0001 in the same cycle; next cycle fifo_wr_en=1 and fifo_data_in=0xA5; level=1.
- wr_req=1111 held for 6 cycles -> grant order 0,1,2,3,0,1; level=6.
- Fill to level=32 with wr_req=0010 held -> wr_gnt=0 and err=0. Then rd_req for 1 cycle -> rd_gnt=1, level=31, and req1 is granted on the next cycle. rd_valid pulses 2 cycles after rd_gnt with rd_data equal to the first word written.
- level=5, wr_req=0001 and rd_req held for 4 cycles -> grants W,R,W,R; level goes 6,5,6,5; fifo_wr_en and fifo_rd_en are never high together.
- level=0, rd_req=1 -> rd_gnt=0 and no fifo_rd_en. Separately, force fifo_full=1 while fifo_wr_en=1 -> err=1 and stays 1 until reset.
